// File: rtl/sync_fifo_ctrl_buffer.sv
//==============================================================================
// Module   : sync_fifo_ctrl_buffer
// Brief    : Single-clock FIFO with pointer control, occupancy level,
//            almost-full/almost-empty thresholds and sticky error flags.
//            Define SYNC_FIFO_FWFT_EN for first-word fall-through read data.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_fifo_ctrl_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDRESS_BITS = 3,
    parameter int AF_LEVEL     = 6,
    parameter int AE_LEVEL     = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WINC,
    input  logic [DATA_WIDTH-1:0]   W_DATA,
    input  logic                    RINC,
    input  logic                    CLR_ERR,
    output logic [DATA_WIDTH-1:0]   R_DATA,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [ADDRESS_BITS:0]   LEVEL,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam logic [ADDRESS_BITS-1:0] c_LAST_PTR  = ADDRESS_BITS'(FIFO_DEPTH - 1);
    localparam logic [ADDRESS_BITS:0]   c_DEPTH_LVL = (ADDRESS_BITS + 1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_BITS:0]   c_AF_LVL    = (ADDRESS_BITS + 1)'(AF_LEVEL);
    localparam logic [ADDRESS_BITS:0]   c_AE_LVL    = (ADDRESS_BITS + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0]   r_mem [0:FIFO_DEPTH-1];
    logic [ADDRESS_BITS-1:0] r_wr_ptr;
    logic [ADDRESS_BITS-1:0] r_rd_ptr;
    logic [ADDRESS_BITS:0]   r_level;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_almost_full;
    logic                    r_almost_empty;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic [ADDRESS_BITS-1:0] w_wr_ptr_nxt;
    logic [ADDRESS_BITS-1:0] w_rd_ptr_nxt;
    logic [ADDRESS_BITS:0]   w_level_nxt;
    logic [DATA_WIDTH-1:0]   w_rdata_nxt;
`ifdef SYNC_FIFO_FWFT_EN
    logic [ADDRESS_BITS:0]   w_level_after_pop;
`endif

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        w_rd_acc     = RINC & ~r_empty;
        w_wr_acc     = WINC & (~r_full | w_rd_acc);
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The new head is the incoming word when nothing older survives the pop.
    always_comb begin
        w_level_after_pop = r_level - {{ADDRESS_BITS{1'b0}}, w_rd_acc};
        if (w_level_nxt == '0) begin
            w_rdata_nxt = '0;
        end else if (w_wr_acc && (w_level_after_pop == '0)) begin
            w_rdata_nxt = W_DATA;
        end else begin
            w_rdata_nxt = r_mem[w_rd_ptr_nxt];
        end
    end
`else
    always_comb begin
        w_rdata_nxt = w_rd_acc ? r_mem[r_rd_ptr] : r_rdata;
    end
`endif

    always_ff @(posedge CLK) begin
        if (w_wr_acc && !RST) begin
            r_mem[r_wr_ptr] <= W_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_rdata        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_level        <= w_level_nxt;
            r_rdata        <= w_rdata_nxt;
            r_full         <= (w_level_nxt == c_DEPTH_LVL);
            r_empty        <= (w_level_nxt == '0);
            r_almost_full  <= (w_level_nxt >= c_AF_LVL);
            r_almost_empty <= (w_level_nxt <= c_AE_LVL);
            // A new error event outranks a simultaneous clear.
            if (WINC && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (CLR_ERR) begin
                r_overflow <= 1'b0;
            end
            if (RINC && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (CLR_ERR) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign R_DATA       = r_rdata;
    assign FULL         = r_full;
    assign EMPTY        = r_empty;
    assign ALMOST_FULL  = r_almost_full;
    assign ALMOST_EMPTY = r_almost_empty;
    assign LEVEL        = r_level;
    assign OVERFLOW     = r_overflow;
    assign UNDERFLOW    = r_underflow;

endmodule

`default_nettype wire
